// File: rtl/fir_output_stage_if.sv
// Bundle between the FIR control/MAC side, the output stage and the downstream consumer.
// The master modport is the environment; the slave modport is the output stage.
interface fir_output_stage_if #(
    parameter int TAP_W = 3,
    parameter int ACC_W = 20,
    parameter int OUT_W = 8
);
    logic             en;
    logic             mac_init;
    logic [TAP_W-1:0] tap_address;
    logic [ACC_W-1:0] acc_in;
    logic             ready_out;
    logic [OUT_W-1:0] y;
    logic             valid_out;
    logic             busy;
    logic             seq_err;
    logic             overflow;

    modport master (
        output en, mac_init, tap_address, acc_in, ready_out,
        input  y, valid_out, busy, seq_err, overflow
    );

    modport slave (
        input  en, mac_init, tap_address, acc_in, ready_out,
        output y, valid_out, busy, seq_err, overflow
    );
endinterface

// File: rtl/fir_output_stage.sv
// Follows the FIR tap sweep, captures the accumulator MAC_LAT cycles after the last tap,
// rounds/saturates it and queues it in a small FIFO for a valid/ready consumer.
//
//  state    | meaning
//  ST_IDLE  | waiting for tap 0 with en high
//  ST_SWEEP | inside a sweep, exp_tap is the next tap address expected
module fir_output_stage #(
    parameter int NTAPS      = 8,
    parameter int TAP_W      = 3,
    parameter int ACC_W      = 20,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 8,
    parameter int MAC_LAT    = 1,
    parameter int DEPTH      = 2
) (
    input  logic                clock,
    input  logic                reset,
    fir_output_stage_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [0:0]       state;
    logic [TAP_W-1:0] exp_tap;
    logic             start, tap_ok, last_tap, abort;
    logic             seq_err_q;
    logic             unused_mac_init;

    assign unused_mac_init = bus.mac_init;

    always_comb begin
        start    = bus.en && (bus.tap_address == '0);
        tap_ok   = bus.en && (bus.tap_address == exp_tap);
        last_tap = (state == ST_SWEEP) && tap_ok && (exp_tap == TAP_W'(NTAPS - 1));
        abort    = (state == ST_SWEEP) && !tap_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            exp_tap   <= '0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= abort;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SWEEP;
                        exp_tap <= TAP_W'(1);
                    end
                end
                default: begin
                    if (tap_ok) begin
                        if (last_tap) state <= ST_IDLE;
                        else          exp_tap <= exp_tap + TAP_W'(1);
                    end else if (start) begin
                        // abort cycle that already carries tap 0 restarts without losing it
                        exp_tap <= TAP_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    logic [MAC_LAT-1:0] pipe;
    logic               capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= last_tap;
            for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign capture = pipe[MAC_LAT-1];

    logic signed [ACC_W:0] acc_ext, rnd;
    logic        [OUT_W-1:0] sat;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W - 1)));

    assign acc_ext = {bus.acc_in[ACC_W-1], bus.acc_in};

    generate
        if (FRAC_SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_SHIFT - 1);
            assign rnd = (acc_ext + HALF) >>> FRAC_SHIFT;
        end else begin : g_pass
            assign rnd = acc_ext;
        end
    endgenerate

    always_comb begin
        if (rnd > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
        else if (rnd < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
        else                    sat = rnd[OUT_W-1:0];
    end

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] y_hold;
    logic             overflow_q;
    logic             valid, full, pop, push_ok;

    always_comb begin
        valid   = (count != '0);
        full    = (count == CNT_W'(DEPTH));
        pop     = valid && bus.ready_out;
        // when full, a same-cycle pop frees the slot the push lands in
        push_ok = capture && (!full || pop);
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= sat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            y_hold     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (capture && full && !pop) overflow_q <= 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                y_hold <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.y         = valid ? mem[rd_ptr] : y_hold;
    assign bus.valid_out = valid;
    assign bus.busy      = full || ((count == CNT_W'(DEPTH - 1)) && (|pipe));
    assign bus.seq_err   = seq_err_q;
    assign bus.overflow  = overflow_q;
endmodule
